// File: rtl/sprite_eval.sv
`default_nettype none
// sprite_eval: per-scanline scan of 64 SPRAM entries. The first MAX_SPR
// in-range sprites are copied into a secondary buffer with a registered read port.
module sprite_eval #(
   parameter int MAX_SPR = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_eval_start,
   input  logic [8:0] i_scanline,
   input  logic       i_sprite_size,
   output logic [7:0] o_spram_ppu_addr,
   input  logic [7:0] i_spram_ppu_data,
   input  logic [4:0] i_sec_rd_addr,
   output logic [7:0] o_sec_rd_data,
   output logic       o_eval_busy,
   output logic       o_eval_done,
   output logic [3:0] o_sprite_count,
   output logic       o_sprite_overflow,
   output logic       o_sprite0_present
);

   localparam int BUF_BYTES = 4 * MAX_SPR;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_READ_Y = 3'd2,
      S_CHECK  = 3'd3,
      S_COPY   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t     r_state;
   logic [8:0] r_scan;
   logic       r_tall;
   logic [5:0] r_n;
   logic [1:0] r_b;
   logic [4:0] r_clr;
   logic [3:0] r_count;
   logic       r_ov;
   logic       r_s0;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_rd;
   logic [7:0] r_sec [BUF_BYTES];

   logic [9:0] w_diff;
   logic [8:0] w_height;
   logic       w_in_range;
   logic       w_has_room;
   logic [4:0] w_slot_base;
   logic       w_we;
   logic [4:0] w_waddr;
   logic [7:0] w_wdata;
   logic [1:0] w_b_next;

   // Borrow out of the 10-bit subtract means the sprite starts below the scanline.
   assign w_diff      = {1'b0, r_scan} - {2'b00, i_spram_ppu_data};
   assign w_height    = r_tall ? 9'd16 : 9'd8;
   assign w_in_range  = !w_diff[9] && (w_diff[8:0] < w_height);
   assign w_has_room  = r_count < 4'(MAX_SPR);
   assign w_slot_base = {r_count[2:0], 2'b00};
   assign w_b_next    = (r_b == 2'd3) ? 2'd3 : r_b + 2'd1;

   always_comb begin
      o_spram_ppu_addr = 8'd0;
      case (r_state)
         S_READ_Y: o_spram_ppu_addr = {r_n, 2'b00};
         S_CHECK:  o_spram_ppu_addr = {r_n, 2'b01};
         S_COPY:   o_spram_ppu_addr = {r_n, w_b_next};
         default:  o_spram_ppu_addr = 8'd0;
      endcase
   end

   always_comb begin
      w_we    = 1'b0;
      w_waddr = 5'd0;
      w_wdata = 8'd0;
      case (r_state)
         S_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_clr;
            w_wdata = 8'hFF;
         end
         S_CHECK: begin
            w_we    = w_in_range && w_has_room;
            w_waddr = w_slot_base;
            w_wdata = i_spram_ppu_data;
         end
         S_COPY: begin
            w_we    = 1'b1;
            w_waddr = w_slot_base | {3'b000, r_b};
            w_wdata = i_spram_ppu_data;
         end
         default: w_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) r_sec[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rd <= 8'd0;
      else      r_rd <= r_sec[i_sec_rd_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_scan  <= 9'd0;
         r_tall  <= 1'b0;
         r_n     <= 6'd0;
         r_b     <= 2'd0;
         r_clr   <= 5'd0;
         r_count <= 4'd0;
         r_ov    <= 1'b0;
         r_s0    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_eval_start) begin
               r_scan  <= i_scanline;
               r_tall  <= i_sprite_size;
               r_count <= 4'd0;
               r_ov    <= 1'b0;
               r_s0    <= 1'b0;
               r_n     <= 6'd0;
               r_clr   <= 5'd0;
               r_busy  <= 1'b1;
               r_state <= S_CLEAR;
            end
            S_CLEAR: begin
               r_clr <= r_clr + 5'd1;
               if (r_clr == 5'(BUF_BYTES - 1)) r_state <= S_READ_Y;
            end
            S_READ_Y: r_state <= S_CHECK;
            S_CHECK: begin
               if (w_in_range && w_has_room) begin
                  if (r_n == 6'd0) r_s0 <= 1'b1;
                  r_b     <= 2'd1;
                  r_state <= S_COPY;
               end else if (w_in_range || r_n == 6'd63) begin
                  if (w_in_range) r_ov <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_n     <= r_n + 6'd1;
                  r_state <= S_READ_Y;
               end
            end
            S_COPY: begin
               if (r_b != 2'd3) begin
                  r_b <= r_b + 2'd1;
               end else begin
                  r_count <= r_count + 4'd1;
                  if (r_n == 6'd63) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_n     <= r_n + 6'd1;
                     r_state <= S_READ_Y;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_sec_rd_data     = r_rd;
   assign o_eval_busy       = r_busy;
   assign o_eval_done       = r_done;
   assign o_sprite_count    = r_count;
   assign o_sprite_overflow = r_ov;
   assign o_sprite0_present = r_s0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_eval.sv
`default_nettype none
// tb_sprite_eval: directed and randomized sprite evaluations checked against
// a loop-based reference model of the scan rules.
module tb_sprite_eval;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       i_eval_start = 1'b0;
   logic [8:0] i_scanline = 9'd0;
   logic       i_sprite_size = 1'b0;
   logic [7:0] o_spram_ppu_addr;
   logic [7:0] i_spram_ppu_data;
   logic [4:0] i_sec_rd_addr = 5'd0;
   logic [7:0] o_sec_rd_data;
   logic       o_eval_busy;
   logic       o_eval_done;
   logic [3:0] o_sprite_count;
   logic       o_sprite_overflow;
   logic       o_sprite0_present;

   always #5 clk = ~clk;

   sprite_eval #(.MAX_SPR(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_eval_start      (i_eval_start),
      .i_scanline        (i_scanline),
      .i_sprite_size     (i_sprite_size),
      .o_spram_ppu_addr  (o_spram_ppu_addr),
      .i_spram_ppu_data  (i_spram_ppu_data),
      .i_sec_rd_addr     (i_sec_rd_addr),
      .o_sec_rd_data     (o_sec_rd_data),
      .o_eval_busy       (o_eval_busy),
      .o_eval_done       (o_eval_done),
      .o_sprite_count    (o_sprite_count),
      .o_sprite_overflow (o_sprite_overflow),
      .o_sprite0_present (o_sprite0_present)
   );

   // SPRAM: registered read, data valid the cycle after the address.
   logic [7:0] spram [256];
   always @(posedge clk) i_spram_ppu_data <= spram[o_spram_ppu_addr];

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_sec [32];
   int         m_cnt;
   int         m_lat;
   bit         m_ov;
   bit         m_s0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_spram(input logic [7:0] v);
      for (int i = 0; i < 256; i++) spram[i] = v;
   endtask

   task automatic model(input int scan, input bit size);
      int h;
      h     = size ? 16 : 8;
      m_cnt = 0;
      m_ov  = 0;
      m_s0  = 0;
      m_lat = 1 + 32;
      for (int i = 0; i < 32; i++) m_sec[i] = 8'hFF;
      for (int n = 0; n < 64; n++) begin
         int y;
         y = spram[4*n];
         if (scan >= y && scan - y < h) begin
            if (m_cnt == 8) begin
               m_ov  = 1;
               m_lat += 2;
               break;
            end
            for (int b = 0; b < 4; b++) m_sec[4*m_cnt+b] = spram[4*n+b];
            if (n == 0) m_s0 = 1;
            m_cnt++;
            m_lat += 5;
         end else begin
            m_lat += 2;
         end
      end
      m_lat += 1;
   endtask

   // dup_at > 0 re-pulses start (with a different scanline) while busy.
   task automatic run_eval(input string tag, input int scan, input bit size, input int dup_at);
      int k;
      bit seen;
      model(scan, size);
      @(negedge clk);
      i_scanline    = scan[8:0];
      i_sprite_size = size;
      i_eval_start  = 1'b1;
      @(posedge clk);
      #1 i_eval_start = 1'b0;
      k    = 0;
      seen = 0;
      while (!seen && k < 400) begin
         @(posedge clk);
         k++;
         #1;
         if (k == dup_at) begin
            i_eval_start = 1'b1;
            i_scanline   = scan[8:0] ^ 9'h1AA;
         end else begin
            i_eval_start = 1'b0;
         end
         if (k == 5) check({tag, " busy"}, o_eval_busy, 1);
         seen = o_eval_done;
      end
      check({tag, " done_seen"}, seen, 1);
      check({tag, " latency"}, k + 2, m_lat);
      // start in the DONE cycle must be ignored
      i_eval_start = 1'b1;
      @(posedge clk);
      #1 i_eval_start = 1'b0;
      check({tag, " start_in_done_ignored"}, o_eval_busy, 0);
      check({tag, " done_pulse_width"}, o_eval_done, 0);
      check({tag, " count"}, o_sprite_count, m_cnt);
      check({tag, " overflow"}, o_sprite_overflow, m_ov);
      check({tag, " sprite0"}, o_sprite0_present, m_s0);
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         i_sec_rd_addr = a[4:0];
         @(negedge clk);
         check($sformatf("%s sec[%0d]", tag, a), o_sec_rd_data, m_sec[a]);
      end
   endtask

   initial begin
      fill_spram(8'hFF);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset addr", o_spram_ppu_addr, 0);
      check("reset busy", o_eval_busy, 0);
      check("reset done", o_eval_done, 0);
      check("reset count", o_sprite_count, 0);
      check("reset overflow", o_sprite_overflow, 0);
      check("reset sprite0", o_sprite0_present, 0);
      check("reset rd_data", o_sec_rd_data, 0);
      @(negedge clk);
      rst = 1'b1;

      run_eval("empty", 10, 1'b0, 0);

      spram[0] = 8'h20; spram[1] = 8'h05; spram[2] = 8'h01; spram[3] = 8'h40;
      run_eval("s0_hit", 9'h027, 1'b0, 0);
      run_eval("s0_past", 9'h028, 1'b0, 0);
      run_eval("s0_tall_edge", 9'h02F, 1'b1, 0);
      run_eval("s0_tall_past", 9'h030, 1'b1, 0);
      run_eval("s0_borrow", 9'h01F, 1'b1, 0);

      fill_spram(8'hFF);
      for (int s = 3; s <= 11; s++) begin
         spram[4*s]   = 8'h50;
         spram[4*s+1] = 8'(s);
         spram[4*s+2] = 8'(s * 3);
         spram[4*s+3] = 8'(s + 8'h80);
      end
      run_eval("overflow_dup_start", 9'h052, 1'b0, 7);

      // Reset in the middle of copying sprite 0
      fill_spram(8'hFF);
      spram[0] = 8'h20; spram[1] = 8'h11; spram[2] = 8'h22; spram[3] = 8'h33;
      @(negedge clk);
      i_scanline    = 9'h024;
      i_sprite_size = 1'b0;
      i_eval_start  = 1'b1;
      @(posedge clk);
      #1 i_eval_start = 1'b0;
      repeat (35) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset addr", o_spram_ppu_addr, 0);
      check("midreset busy", o_eval_busy, 0);
      check("midreset done", o_eval_done, 0);
      check("midreset count", o_sprite_count, 0);
      check("midreset sprite0", o_sprite0_present, 0);
      check("midreset rd_data", o_sec_rd_data, 0);
      @(negedge clk);
      rst = 1'b1;
      run_eval("after_reset", 9'h024, 1'b0, 0);

      for (int r = 0; r < 6; r++) begin
         int scan;
         bit size;
         scan = $urandom_range(0, 261);
         size = 1'($urandom_range(0, 1));
         for (int i = 0; i < 256; i++) spram[i] = 8'($urandom_range(0, 255));
         for (int n = 0; n < 64; n++) begin
            if ($urandom_range(0, 2) == 0) begin
               int d;
               int y;
               d = $urandom_range(0, 17);
               y = scan - d;
               if (y < 0 || y > 255) y = $urandom_range(0, 255);
               spram[4*n] = 8'(y);
            end
         end
         run_eval($sformatf("rand%0d", r), scan, size, (r == 2) ? 40 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
